// File: rtl/trivium_decrypt.sv
// rtl/trivium_decrypt.sv - Trivium keystream receiver: XORs ciphertext bytes back to plaintext.
// Keystream bits are consumed LSB first, one per state update, bit-exact with the transmit side.
module trivium_decrypt #(
  parameter logic [79:0] KEY    = 80'h9719CFC92A9FF688F9AA,
  parameter logic [79:0] IV     = 80'hECBB76B09AFF71D0D151,
  parameter int          WARMUP = 1152
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        resync,
  input  logic        ct_valid,
  output logic        ct_ready,
  input  logic [7:0]  ct_data,
  output logic        pt_valid,
  input  logic        pt_ready,
  output logic [7:0]  pt_data,
  output logic        keyed,
  output logic [15:0] byte_count
);

  typedef enum logic [1:0] {WARM, IDLE, GEN, HOLD} state_t;

  localparam logic [287:0] LOAD      = {KEY, 13'd0, IV, 112'd0, 3'b111};
  localparam logic [10:0]  WARM_LAST = 11'(WARMUP - 1);

  state_t        state_q, state_d;
  logic [287:0]  s_q, s_d;
  logic [10:0]   warm_cnt_q, warm_cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    pt_data_q, pt_data_d;
  logic [15:0]   byte_count_q, byte_count_d;

  logic          t1, t2, t3, z, n1, n2, n3;
  logic [287:0]  s_next;

  always_comb begin
    t1     = s_q[222] ^ s_q[195];
    t2     = s_q[126] ^ s_q[111];
    t3     = s_q[45]  ^ s_q[0];
    z      = t1 ^ t2 ^ t3;
    n1     = t1 ^ (s_q[196] & s_q[197]) ^ s_q[117];
    n2     = t2 ^ (s_q[112] & s_q[113]) ^ s_q[24];
    n3     = t3 ^ (s_q[2]   & s_q[1])   ^ s_q[219];
    s_next = {n3, s_q[287:196], n1, s_q[194:112], n2, s_q[110:1]};
  end

  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    warm_cnt_d   = warm_cnt_q;
    idx_d        = idx_q;
    pt_data_d    = pt_data_q;
    byte_count_d = byte_count_q;
    if (resync) begin
      s_d          = LOAD;
      state_d      = WARM;
      warm_cnt_d   = 11'd0;
      idx_d        = 3'd0;
      byte_count_d = 16'd0;
    end else begin
      case (state_q)
        WARM: begin
          s_d = s_next;
          if (warm_cnt_q == WARM_LAST) begin
            warm_cnt_d = 11'd0;
            state_d    = IDLE;
          end else begin
            warm_cnt_d = warm_cnt_q + 11'd1;
          end
        end
        IDLE: begin
          if (ct_valid) begin
            // Ciphertext is decrypted in place, one bit per GEN cycle.
            pt_data_d = ct_data;
            idx_d     = 3'd0;
            state_d   = GEN;
          end
        end
        GEN: begin
          s_d              = s_next;
          pt_data_d[idx_q] = pt_data_q[idx_q] ^ z;
          idx_d            = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = HOLD;
        end
        HOLD: begin
          if (pt_ready) begin
            byte_count_d = byte_count_q + 16'd1;
            state_d      = IDLE;
          end
        end
        default: state_d = WARM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= WARM;
      s_q          <= LOAD;
      warm_cnt_q   <= 11'd0;
      idx_q        <= 3'd0;
      pt_data_q    <= 8'd0;
      byte_count_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      warm_cnt_q   <= warm_cnt_d;
      idx_q        <= idx_d;
      pt_data_q    <= pt_data_d;
      byte_count_q <= byte_count_d;
    end
  end

  assign ct_ready   = (state_q == IDLE);
  assign pt_valid   = (state_q == HOLD);
  assign keyed      = (state_q != WARM);
  assign pt_data    = pt_data_q;
  assign byte_count = byte_count_q;

endmodule

// File: tb/tb_trivium_decrypt.sv
// tb/tb_trivium_decrypt.sv - directed bench for trivium_decrypt with a Trivium reference model.
// The model uses the conventional 1-based s1..s288 register numbering.
module tb_trivium_decrypt;

  localparam logic [79:0] KEY = 80'h9719CFC92A9FF688F9AA;
  localparam logic [79:0] IV  = 80'hECBB76B09AFF71D0D151;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        resync = 1'b0;
  logic        ct_valid = 1'b0;
  logic        ct_ready;
  logic [7:0]  ct_data = 8'h00;
  logic        pt_valid;
  logic        pt_ready = 1'b1;
  logic [7:0]  pt_data;
  logic        keyed;
  logic [15:0] byte_count;

  int n_cmp  = 0;
  int n_fail = 0;

  bit         ms [1:288];
  logic [79:0] key_v = KEY;
  logic [79:0] iv_v  = IV;

  trivium_decrypt #(.KEY(KEY), .IV(IV), .WARMUP(1152)) dut (
    .clk(clk), .rst(rst), .resync(resync),
    .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_data(ct_data),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data),
    .keyed(keyed), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_load();
    for (int i = 1; i <= 288; i++) ms[i] = 1'b0;
    for (int i = 1; i <= 80; i++) ms[i] = key_v[80-i];
    for (int j = 1; j <= 80; j++) ms[93+j] = iv_v[80-j];
    ms[286] = 1'b1; ms[287] = 1'b1; ms[288] = 1'b1;
  endtask

  task automatic m_step(output bit z);
    bit a, b, c;
    a = ms[66] ^ ms[93];
    b = ms[162] ^ ms[177];
    c = ms[243] ^ ms[288];
    z = a ^ b ^ c;
    a = a ^ (ms[91] & ms[92]) ^ ms[171];
    b = b ^ (ms[175] & ms[176]) ^ ms[264];
    c = c ^ (ms[286] & ms[287]) ^ ms[69];
    for (int i = 288; i >= 179; i--) ms[i] = ms[i-1];
    ms[178] = b;
    for (int i = 177; i >= 95; i--) ms[i] = ms[i-1];
    ms[94] = a;
    for (int i = 93; i >= 2; i--) ms[i] = ms[i-1];
    ms[1] = c;
  endtask

  task automatic m_rekey();
    bit z;
    m_load();
    for (int i = 0; i < 1152; i++) m_step(z);
  endtask

  task automatic m_byte(output logic [7:0] b);
    bit z;
    for (int i = 0; i < 8; i++) begin
      m_step(z);
      b[i] = z;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Sends one byte; hold>0 stalls pt_ready in HOLD, stay leaves the DUT parked in HOLD.
  task automatic send_byte(input string tag, input logic [7:0] ct, input logic [7:0] exp_pt,
                           input int hold, input bit stay);
    int waited = 0;
    logic bad = 1'b0;
    logic [7:0] ref_pt;
    while (!ct_ready && waited < 3000) begin
      tick();
      waited++;
    end
    chk({tag, "_ready"}, 32'(ct_ready), 32'd1);
    ct_data  = ct;
    ct_valid = 1'b1;
    pt_ready = (hold == 0);
    tick();
    ct_data = 8'hFF;
    for (int i = 0; i < 7; i++) begin
      bad = bad | pt_valid | ct_ready;
      tick();
    end
    bad = bad | pt_valid | ct_ready;
    chk({tag, "_early"}, 32'(bad), 32'd0);
    tick();
    ct_valid = 1'b0;
    chk({tag, "_valid"}, 32'(pt_valid), 32'd1);
    chk({tag, "_data"}, 32'(pt_data), 32'(exp_pt));
    if (hold > 0) begin
      ref_pt = pt_data;
      bad = 1'b0;
      for (int i = 0; i < hold; i++) begin
        tick();
        bad = bad | ct_ready | !pt_valid | (pt_data !== ref_pt);
      end
      chk({tag, "_stall"}, 32'(bad), 32'd0);
      if (stay) return;
      pt_ready = 1'b1;
    end
    tick();
    chk({tag, "_done"}, 32'(pt_valid), 32'd0);
  endtask

  initial begin
    logic [7:0] ks;
    logic [7:0] msg [5];
    logic bad;
    msg[0] = 8'h48; msg[1] = 8'h45; msg[2] = 8'h4C; msg[3] = 8'h4C; msg[4] = 8'h4F;

    #12;
    chk("rst_ct_ready", 32'(ct_ready), 32'd0);
    chk("rst_pt_valid", 32'(pt_valid), 32'd0);
    chk("rst_pt_data", 32'(pt_data), 32'd0);
    chk("rst_keyed", 32'(keyed), 32'd0);
    chk("rst_byte_count", 32'(byte_count), 32'd0);

    // Warm-up length, with ct_valid held high the whole time.
    @(negedge clk);
    rst = 1'b1;
    ct_valid = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 1151; i++) begin
      tick();
      bad = bad | ct_ready | keyed;
    end
    chk("warm_early", 32'(bad), 32'd0);
    tick();
    chk("warm_ct_ready", 32'(ct_ready), 32'd1);
    chk("warm_keyed", 32'(keyed), 32'd1);

    m_rekey();
    for (int i = 0; i < 4; i++) begin
      m_byte(ks);
      send_byte($sformatf("ks%0d", i), 8'h00, ks, 0, 1'b0);
    end
    chk("ks_count", 32'(byte_count), 32'd4);

    // Resync from IDLE, then HELLO.
    resync = 1'b1;
    tick();
    resync = 1'b0;
    chk("resync_idle_count", 32'(byte_count), 32'd0);
    chk("resync_idle_keyed", 32'(keyed), 32'd0);
    m_rekey();
    for (int i = 0; i < 5; i++) begin
      m_byte(ks);
      send_byte($sformatf("hello%0d", i), msg[i] ^ ks, msg[i], 0, 1'b0);
    end
    chk("hello_count", 32'(byte_count), 32'd5);

    // Back-pressure in HOLD.
    m_byte(ks);
    send_byte("stall", 8'h3C ^ ks, 8'h3C, 20, 1'b0);
    m_byte(ks);
    send_byte("after_stall", 8'hC3 ^ ks, 8'hC3, 0, 1'b0);
    chk("stall_count", 32'(byte_count), 32'd7);

    // Resync in the middle of GEN drops the byte.
    ct_data = 8'h00;
    ct_valid = 1'b1;
    tick();
    ct_valid = 1'b0;
    tick(); tick(); tick();
    resync = 1'b1;
    tick();
    resync = 1'b0;
    chk("gen_resync_count", 32'(byte_count), 32'd0);
    bad = 1'b0;
    for (int i = 0; i < 1151; i++) begin
      bad = bad | ct_ready | pt_valid | keyed;
      tick();
    end
    bad = bad | ct_ready | pt_valid;
    chk("gen_resync_quiet", 32'(bad), 32'd0);
    tick();
    chk("gen_resync_ready", 32'(ct_ready), 32'd1);
    m_rekey();
    m_byte(ks);
    send_byte("resync_ks0", 8'h00, ks, 0, 1'b0);

    // Asynchronous reset while parked in HOLD.
    m_byte(ks);
    send_byte("park", 8'h5A ^ ks, 8'h5A, 3, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_pt_valid", 32'(pt_valid), 32'd0);
    chk("arst_ct_ready", 32'(ct_ready), 32'd0);
    chk("arst_keyed", 32'(keyed), 32'd0);
    chk("arst_pt_data", 32'(pt_data), 32'd0);
    chk("arst_byte_count", 32'(byte_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
